mips_cpu_lsu: RTL
=================

# mips_cpu_lsu

Load/store unit for the Harvard MIPS core. It sits between the datapath's memory stage and the data-memory port, and is driven by the decoder's `Memread`/`Memwrite` strobes, the load/store opcode, the ALU effective address and `rt`. It turns each access into a single Avalon-MM-style word transaction with byte enables and stalls the core until the transaction completes. It returns load results already aligned, sign- or zero-extended, or merged for LWL/LWR.

## Interface
Parameters:
- none (32-bit data, 32-bit byte address, little-endian, all fixed)

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `mem_read`  in  1  load request from decoder; held stable while `stall`=1
- `mem_write`  in  1  store request from decoder; held stable while `stall`=1
- `opcode`  in  6  instruction[31:26]: 32 LB, 33 LH, 34 LWL, 35 LW, 36 LBU, 37 LHU, 38 LWR, 40 SB, 41 SH, 43 SW
- `addr`  in  32  effective byte address (ALU result)
- `rt_data`  in  32  store data, and old `rt` value for LWL/LWR merge
- `stall`  out  1  core must hold PC/pipeline state
- `load_data`  out  32  final register write value; valid when `load_valid`=1
- `load_valid`  out  1  one-cycle pulse when a load completes
- `addr_error`  out  1  one-cycle pulse on a misaligned or illegal request
- `avm_address`  out  32  word address, `{addr[31:2],2'b00}`
- `avm_read`  out  1  bus read strobe
- `avm_write`  out  1  bus write strobe
- `avm_writedata`  out  32  lane-shifted store data
- `avm_byteenable`  out  4  active byte lanes
- `avm_readdata`  in  32  read data; sampled in the cycle `avm_read`=1 and `avm_waitrequest`=0
- `avm_waitrequest`  in  1  slave not ready; bus outputs held while high

## Operation
- FSM has three states: IDLE, BUS, DONE.
- IDLE:
  - `req = mem_read | mem_write`. On `req`, latch opcode, addr, rt_data and go to BUS.
  - If the request is illegal, go to DONE with the error flag set and issue no bus cycle.
  - Illegal means: both strobes high; opcode not in the list for the strobe; LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0. LB/LBU/SB/LWL/LWR are never misaligned.
- BUS: assert `avm_read` or `avm_write`, address, byteenable and writedata from registered values. Stay while `avm_waitrequest`=1. On the cycle it is 0, capture readdata (loads) and go to DONE.
- DONE:
  - Pulse `load_valid` (legal loads) or `addr_error`. Stores pulse neither.
  - Return to IDLE. A request present in DONE is ignored; the core advances on this cycle.
- Byte lane k is bits [8k+7:8k]. Let n=`addr[1:0]`.
- Store byteenable / writedata:
  - SB: `4'b0001<<n`, data `{4{rt[7:0]}}`.
  - SH: `4'b0011<<n`, data `{2{rt[15:0]}}`.
  - SW: `4'b1111`, data `rt`.
- Loads always use byteenable `4'b1111`.
- Load extraction (w = captured word):
  - LB/LBU: byte n, sign/zero-extended.
  - LH/LHU: half at n, sign/zero-extended.
  - LW: w.
  - LWL: `(w << 8*(3-n)) | (rt & ~(32'hFFFFFFFF << 8*(3-n)))`.
  - LWR: `(w >> 8*n) | (rt & ~(32'hFFFFFFFF >> 8*n))`.
- `load_data` is registered and holds its value until the next load completes.

## Timing
- Combinational `stall = (IDLE & req) | BUS`. `stall` is low in DONE and in IDLE with no request.
- Minimum latency with zero wait states: request seen in IDLE (cycle 0) → bus strobe in cycle 1 → DONE with `load_valid` in cycle 2. Each wait-state cycle adds one cycle.
- Illegal request: IDLE (cycle 0) → DONE with `addr_error` in cycle 1. No bus strobe.
- Bus outputs come from registers and stay constant throughout BUS. `avm_read`/`avm_write` are 0 outside BUS.
- Reset (`reset_n`=0 at a rising edge), including mid-BUS:
  - FSM returns to IDLE and the transaction is abandoned.
  - All outputs go to 0: `stall` (with no req), `load_data`, `load_valid`, `addr_error`, `avm_*`.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - opcode localparams (OP_LB … OP_SW);
  - `lsu_state_t` enum {IDLE, BUS, DONE}.
- One combinational sub-module, `mips_cpu_lsu_align`, takes (opcode, n, w, rt) and produces `load_data`. The FSM, store lane steering and error checks stay in `mips_cpu_lsu`.

## Test plan
- SW addr 0x100, rt 0xDEADBEEF, waitrequest 0 → cycle 1: write, address 0x100, byteenable 4'hF, writedata 0xDEADBEEF. Stall 1 for cycles 0–1, 0 in cycle 2.
- LB addr 0x203, readdata 0x80123456, 3 wait states → single read held 4 cycles, address 0x200. `load_data` 0xFFFFFF80 with `load_valid` pulse 1 cycle after the acceptance.
- LBU and LHU at addr 0x202 with readdata 0x8001FFFF → 0x00000001 and 0x00008001 respectively. LH at 0x200 → 0xFFFFFFFF.
- LWL n=1, w=0x44332211, rt 0xAABBCCDD → 0x2211CCDD. LWR n=1, same inputs → 0xAA443322.
- SH addr 0x101 and LW addr 0x102 → `addr_error` pulse in cycle 1, no `avm_read`/`avm_write` ever, stall released in cycle 1. SH addr 0x102, rt 0x1234 → byteenable 4'b1100, writedata 0x12341234.
- `reset_n` low during BUS with waitrequest 1 → next cycle `avm_read` 0, state IDLE, all outputs 0. A new LW after reset completes normally.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS core: load/store opcodes and LSU FSM states.
package mips_cpu_pkg;

  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LWL = 6'd34;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_LWR = 6'd38;
  localparam logic [5:0] OP_SB  = 6'd40;
  localparam logic [5:0] OP_SH  = 6'd41;
  localparam logic [5:0] OP_SW  = 6'd43;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Load result formatting: picks the addressed byte/half, extends it, or merges
// the fetched word with the old rt value for the unaligned LWL/LWR pair.
module mips_cpu_lsu_align
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  n,
  input  logic [31:0] w,
  input  logic [31:0] rt,
  output logic [31:0] load_data
);

  logic [4:0]  shr_s;
  logic [4:0]  shl_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Extraction and merge per load opcode; 3-n equals ~n on two bits.
  always_comb begin
    shr_s  = {n, 3'b000};
    shl_s  = {~n, 3'b000};
    byte_s = 8'(w >> shr_s);
    half_s = 16'(w >> shr_s);
    case (opcode)
      OP_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_data = {24'h000000, byte_s};
      OP_LH:   load_data = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_data = {16'h0000, half_s};
      OP_LW:   load_data = w;
      OP_LWL:  load_data = (w << shl_s) | (rt & ~(32'hFFFF_FFFF << shl_s));
      OP_LWR:  load_data = (w >> shr_s) | (rt & ~(32'hFFFF_FFFF >> shr_s));
      default: load_data = w;
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one Avalon-MM word transaction per access, stalling the
// core until it completes; loads return formatted data through the aligner.
module mips_cpu_lsu
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_error,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  lsu_state_t  state_r;
  lsu_state_t  state_nxt_s;
  logic        req_s;
  logic        illegal_s;
  logic        stall_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s;
  logic [31:0] align_s;

  logic [5:0]  opcode_r;
  logic [1:0]  n_r;
  logic [31:0] rt_r;
  logic        avm_read_r;
  logic        avm_write_r;
  logic [31:0] avm_address_r;
  logic [31:0] avm_writedata_r;
  logic [3:0]  avm_byteenable_r;
  logic [31:0] load_data_r;
  logic        load_valid_r;
  logic        addr_error_r;

  // Request legality: strobe/opcode agreement and natural alignment.
  always_comb begin
    req_s     = mem_read | mem_write;
    illegal_s = 1'b0;
    if (mem_read && mem_write) begin
      illegal_s = 1'b1;
    end else if (mem_read) begin
      case (opcode)
        OP_LB, OP_LBU, OP_LWL, OP_LWR: illegal_s = 1'b0;
        OP_LH, OP_LHU:                 illegal_s = addr[0];
        OP_LW:                         illegal_s = (addr[1:0] != 2'b00);
        default:                       illegal_s = 1'b1;
      endcase
    end else if (mem_write) begin
      case (opcode)
        OP_SB:   illegal_s = 1'b0;
        OP_SH:   illegal_s = addr[0];
        OP_SW:   illegal_s = (addr[1:0] != 2'b00);
        default: illegal_s = 1'b1;
      endcase
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Store lane steering: replicate the datum so every candidate lane carries it.
  always_comb begin
    be_s = 4'b1111;
    wd_s = 32'h0000_0000;
    if (mem_write) begin
      case (opcode)
        OP_SB: begin
          be_s = 4'b0001 << addr[1:0];
          wd_s = {4{rt_data[7:0]}};
        end
        OP_SH: begin
          be_s = 4'b0011 << addr[1:0];
          wd_s = {2{rt_data[15:0]}};
        end
        OP_SW: begin
          be_s = 4'b1111;
          wd_s = rt_data;
        end
        default: begin
          be_s = 4'b1111;
          wd_s = rt_data;
        end
      endcase
    end else begin
      be_s = 4'b1111;
      wd_s = 32'h0000_0000;
    end
  end

  // Next-state and stall; illegal requests skip the bus entirely.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        stall_s = req_s;
        if (req_s && illegal_s) begin
          state_nxt_s = DONE;
        end else if (req_s) begin
          state_nxt_s = BUS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUS: begin
        stall_s = 1'b1;
        if (avm_waitrequest) begin
          state_nxt_s = BUS;
        end else begin
          state_nxt_s = DONE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latching, bus output registers and load result capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      opcode_r         <= 6'd0;
      n_r              <= 2'd0;
      rt_r             <= 32'h0000_0000;
      avm_read_r       <= 1'b0;
      avm_write_r      <= 1'b0;
      avm_address_r    <= 32'h0000_0000;
      avm_writedata_r  <= 32'h0000_0000;
      avm_byteenable_r <= 4'b0000;
      load_data_r      <= 32'h0000_0000;
      load_valid_r     <= 1'b0;
      addr_error_r     <= 1'b0;
    end else begin
      load_valid_r <= 1'b0;
      addr_error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            opcode_r <= opcode;
            n_r      <= addr[1:0];
            rt_r     <= rt_data;
            if (illegal_s) begin
              addr_error_r <= 1'b1;
            end else begin
              avm_read_r       <= mem_read;
              avm_write_r      <= mem_write;
              avm_address_r    <= {addr[31:2], 2'b00};
              avm_writedata_r  <= wd_s;
              avm_byteenable_r <= be_s;
            end
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            avm_read_r  <= 1'b0;
            avm_write_r <= 1'b0;
            if (avm_read_r) begin
              load_data_r  <= align_s;
              load_valid_r <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  mips_cpu_lsu_align u_align (
    .opcode    (opcode_r),
    .n         (n_r),
    .w         (avm_readdata),
    .rt        (rt_r),
    .load_data (align_s)
  );

  assign stall          = stall_s;
  assign load_data      = load_data_r;
  assign load_valid     = load_valid_r;
  assign addr_error     = addr_error_r;
  assign avm_address    = avm_address_r;
  assign avm_read       = avm_read_r;
  assign avm_write      = avm_write_r;
  assign avm_writedata  = avm_writedata_r;
  assign avm_byteenable = avm_byteenable_r;

endmodule
